// File: rtl/int_ctrl.sv
// int_ctrl: fixed-priority interrupt controller between external sources
// (DMA, sensor controller, spares) and the CPU CSR unit.
//
// Rising edges on src_i become pending bits. They are masked by a
// software-written enable register and arbitrated lowest-index-first. The
// claim -> service -> mret handshake is tracked so that only one interrupt
// is presented or in service at a time.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   src_i        level interrupt lines, synchronous to clk
//   claim_i      one-cycle pulse: CPU has taken the trap
//   mret_i       one-cycle pulse: CPU executed mret
//   cfg_we       config write strobe
//   cfg_addr     config word address (0 ENABLE, 1 PENDING, 2 STATUS, 3 reserved)
//   cfg_wdata    config write data
//   cfg_rdata    config read data, combinational from cfg_addr
//   int_taken_o  interrupt request to the CSR unit
//   int_id_o     ID of the presented or in-service source
module int_ctrl #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               claim_i,
  input  logic               mret_i,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               int_taken_o,
  output logic [ID_BITS-1:0] int_id_o
);

  localparam int unsigned CFG_AW = 2;
  localparam int unsigned CFG_DW = 32;

  localparam logic [CFG_AW-1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [CFG_AW-1:0] ADDR_PENDING = 2'd1;
  localparam logic [CFG_AW-1:0] ADDR_STATUS  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic [ID_BITS-1:0]   id_nxt;
  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   pending_q;
  logic [NUM_SRC-1:0]   pending_nxt;
  logic [NUM_SRC-1:0]   enable_q;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   cand;
  logic [NUM_SRC-1:0]   clr_w1c;
  logic [NUM_SRC-1:0]   clr_claim;
  logic                 enable_we;
  logic                 win_valid;
  logic [ID_BITS-1:0]   win_id;

  // Only the low NUM_SRC write-data bits map onto register state.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata[CFG_DW-1:NUM_SRC];

  // Edge detect and arbitration inputs.
  assign rise      = src_i & ~src_q;
  assign cand      = pending_q & enable_q;
  assign enable_we = cfg_we && (cfg_addr == ADDR_ENABLE);

  // Clear sources: software W1C and the claim of the presented ID.
  assign clr_w1c   = (cfg_we && (cfg_addr == ADDR_PENDING)) ? cfg_wdata[NUM_SRC-1:0]
                                                            : '0;
  assign clr_claim = ((state_q == REQ) && claim_i) ? (NUM_SRC'(1) << int_id_o)
                                                   : '0;

  // A new rise wins over any clear of the same bit in the same cycle.
  assign pending_nxt = (pending_q & ~(clr_w1c | clr_claim)) | rise;

  // Fixed priority: scan downward so the lowest set index is the last write.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_valid = 1'b1;
        win_id    = ID_BITS'(i);
      end
    end
  end

  // Source sampling, pending and enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      src_q     <= src_i;
      pending_q <= pending_nxt;
      if (enable_we) begin
        enable_q <= cfg_wdata[NUM_SRC-1:0];
      end
    end
  end

  // FSM state, presented ID and request output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      int_id_o    <= '0;
      int_taken_o <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      int_id_o    <= id_nxt;
      int_taken_o <= (state_nxt == REQ);
    end
  end

  // Next-state logic. The ID is latched only on IDLE -> REQ and is held
  // through REQ and SERV, so a higher-priority arrival cannot preempt.
  always_comb begin
    state_nxt = state_q;
    id_nxt    = int_id_o;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          id_nxt    = win_id;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (claim_i) begin
          state_nxt = SERV;
        end else if (!pending_q[int_id_o] || !enable_q[int_id_o]) begin
          // Software withdrew the request before the CPU took it.
          state_nxt = IDLE;
        end
      end
      SERV: begin
        if (mret_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Config read mux.
  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = CFG_DW'(enable_q);
      ADDR_PENDING: cfg_rdata = CFG_DW'(pending_q);
      ADDR_STATUS:  cfg_rdata = CFG_DW'({state_q, int_id_o});
      default:      cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, single source latency, priority and
// no-preemption, masking, withdraw, set-beats-clear, async reset, held source.
module tb_int_ctrl;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned ID_BITS = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] src_i;
  logic               claim_i;
  logic               mret_i;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;
  logic               int_taken_o;
  logic [ID_BITS-1:0] int_id_o;

  int checks = 0;
  int errors = 0;

  int_ctrl #(.NUM_SRC(NUM_SRC), .ID_BITS(ID_BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_i       (src_i),
    .claim_i     (claim_i),
    .mret_i      (mret_i),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .int_taken_o (int_taken_o),
    .int_id_o    (int_id_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    cfg_addr = addr;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic chk_out(input string tag, input logic taken, input logic [ID_BITS-1:0] id);
    chk({tag, "_taken"}, 32'(int_taken_o), 32'(taken));
    chk({tag, "_id"}, 32'(int_id_o), 32'(id));
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  initial begin
    rst       = 1'b1;
    src_i     = '0;
    claim_i   = 1'b0;
    mret_i    = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    #1;
    chk_out("reset", 1'b0, 2'd0);
    tick();
    tick();
    chk_cfg("reset_enable", 2'd0, 32'h0);
    chk_cfg("reset_pending", 2'd1, 32'h0);
    chk_cfg("reset_status", 2'd2, 32'h0);
    chk_cfg("reset_addr3", 2'd3, 32'h0);
    rst = 1'b0;
    tick();

    // Single source: 2-cycle latency, claim, mret.
    cfg_write(2'd0, 32'h1);
    chk_cfg("single_enable_rd", 2'd0, 32'h1);
    src_i = 4'b0001;
    tick();
    src_i = 4'b0000;
    chk_out("single_lat1", 1'b0, 2'd0);
    chk_cfg("single_pend", 2'd1, 32'h1);
    tick();
    chk_out("single_lat2", 1'b1, 2'd0);
    chk_cfg("single_status_req", 2'd2, 32'h4);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    chk_out("single_claim", 1'b0, 2'd0);
    chk_cfg("single_pend_clr", 2'd1, 32'h0);
    chk_cfg("single_status_serv", 2'd2, 32'h8);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk_cfg("single_status_idle", 2'd2, 32'h0);

    // Priority and no preemption.
    cfg_write(2'd0, 32'hF);
    src_i = 4'b1010;
    tick();
    src_i = 4'b0000;
    tick();
    chk_out("prio_first", 1'b1, 2'd1);
    src_i = 4'b0001;
    tick();
    src_i = 4'b0000;
    chk_out("prio_nopreempt", 1'b1, 2'd1);
    chk_cfg("prio_pend", 2'd1, 32'hB);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    chk_cfg("prio_status_serv", 2'd2, 32'h9);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk(  "prio_mret_taken", 32'(int_taken_o), 32'h0);
    tick();
    chk_out("prio_second", 1'b1, 2'd0);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    tick();
    chk_out("prio_third", 1'b1, 2'd3);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    tick();
    chk("prio_drained_taken", 32'(int_taken_o), 32'h0);
    chk_cfg("prio_drained_pend", 2'd1, 32'h0);

    // Masking, then enabling an already-pending source.
    cfg_write(2'd0, 32'h0);
    src_i = 4'b0100;
    tick();
    src_i = 4'b0000;
    tick();
    chk_cfg("mask_pend", 2'd1, 32'h4);
    chk("mask_taken", 32'(int_taken_o), 32'h0);
    cfg_write(2'd0, 32'h4);
    chk("mask_en_edge", 32'(int_taken_o), 32'h0);
    tick();
    chk_out("mask_en_next", 1'b1, 2'd2);

    // Withdraw by W1C while in REQ.
    cfg_write(2'd1, 32'h4);
    chk_cfg("wd_pend", 2'd1, 32'h0);
    tick();
    chk("wd_taken", 32'(int_taken_o), 32'h0);
    chk_cfg("wd_status", 2'd2, 32'h2);
    tick();
    chk("wd_stay_idle", 32'(int_taken_o), 32'h0);

    // Set beats clear; W1C and claim on different bits together.
    cfg_write(2'd0, 32'h1);
    src_i = 4'b0001;
    tick();
    src_i = 4'b0000;
    tick();
    chk_out("sbc_req", 1'b1, 2'd0);
    src_i   = 4'b0001;
    claim_i = 1'b1;
    tick();
    src_i   = 4'b0000;
    claim_i = 1'b0;
    chk("sbc_taken", 32'(int_taken_o), 32'h0);
    chk_cfg("sbc_pend", 2'd1, 32'h1);
    chk_cfg("sbc_status", 2'd2, 32'h8);
    src_i = 4'b0010;
    tick();
    src_i = 4'b0000;
    chk_cfg("sbc_serv_accum", 2'd1, 32'h3);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    tick();
    chk_out("sbc_represent", 1'b1, 2'd0);
    claim_i = 1'b1;
    cfg_write(2'd1, 32'h2);
    claim_i = 1'b0;
    chk_cfg("dual_clear_pend", 2'd1, 32'h0);
    chk("dual_clear_taken", 32'(int_taken_o), 32'h0);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    tick();
    chk("dual_idle_taken", 32'(int_taken_o), 32'h0);

    // Asynchronous reset while in SERV with PENDING=0x6.
    cfg_write(2'd0, 32'h6);
    src_i = 4'b0110;
    tick();
    src_i = 4'b0000;
    tick();
    chk_out("rst_setup_req", 1'b1, 2'd1);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    src_i = 4'b0010;
    tick();
    src_i = 4'b0000;
    chk_cfg("rst_setup_pend", 2'd1, 32'h6);
    chk_cfg("rst_setup_status", 2'd2, 32'h9);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 2'd0);
    chk_cfg("rst_async_pend", 2'd1, 32'h0);
    chk_cfg("rst_async_status", 2'd2, 32'h0);
    chk_cfg("rst_async_enable", 2'd0, 32'h0);
    tick();
    rst = 1'b0;
    cfg_write(2'd0, 32'hF);
    tick();
    tick();
    tick();
    chk("rst_after_taken", 32'(int_taken_o), 32'h0);
    chk_cfg("rst_after_pend", 2'd1, 32'h0);

    // A source held high requests once only.
    src_i = 4'b0001;
    tick();
    tick();
    chk_out("held_req", 1'b1, 2'd0);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    tick();
    tick();
    chk("held_no_repeat", 32'(int_taken_o), 32'h0);
    chk_cfg("held_pend", 2'd1, 32'h0);
    chk_cfg("held_status", 2'd2, 32'h0);
    src_i = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
